// File: rtl/bcd_seq_converter.sv
// Sequential 32-bit binary to 8-digit BCD converter (double dabble, one bit per cycle).
// Results are registered only on the final iteration, so the display never sees partial digits.
module bcd_seq_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] binary_in,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd4,
  output logic [3:0]  bcd5,
  output logic [3:0]  bcd6,
  output logic [3:0]  bcd7,
  output logic [7:0]  blank
);

  typedef enum logic {StIdle, StShift} state_t;

  state_t      state;
  logic [31:0] shift_reg;
  logic [31:0] scratch;
  logic [5:0]  cnt;
  logic        ovf_pend;

  logic [31:0] adj;
  logic [31:0] scratch_nx;
  logic [31:0] shift_nx;
  logic [7:0]  blank_nx;

  // One double-dabble iteration; the bit leaving nibble 7 is dropped (result is mod 10^8).
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 8; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    scratch_nx = {adj[30:0], shift_reg[31]};
    shift_nx   = {shift_reg[30:0], 1'b0};
  end

  // Leading-zero mask of the digits about to be registered; units digit always shown.
  always_comb begin
    blank_nx    = 8'h00;
    blank_nx[7] = (scratch_nx[31:28] == 4'd0);
    for (int i = 6; i >= 1; i--) begin
      blank_nx[i] = blank_nx[i+1] & (scratch_nx[4*i +: 4] == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      shift_reg <= 32'd0;
      scratch   <= 32'd0;
      cnt       <= 6'd0;
      ovf_pend  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd0      <= 4'd0;
      bcd1      <= 4'd0;
      bcd2      <= 4'd0;
      bcd3      <= 4'd0;
      bcd4      <= 4'd0;
      bcd5      <= 4'd0;
      bcd6      <= 4'd0;
      bcd7      <= 4'd0;
      blank     <= 8'hFE;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            shift_reg <= binary_in;
            scratch   <= 32'd0;
            cnt       <= 6'd0;
            ovf_pend  <= (binary_in >= 32'd100_000_000);
            busy      <= 1'b1;
            state     <= StShift;
          end
        end
        StShift: begin
          scratch   <= scratch_nx;
          shift_reg <= shift_nx;
          cnt       <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            bcd0     <= scratch_nx[3:0];
            bcd1     <= scratch_nx[7:4];
            bcd2     <= scratch_nx[11:8];
            bcd3     <= scratch_nx[15:12];
            bcd4     <= scratch_nx[19:16];
            bcd5     <= scratch_nx[23:20];
            bcd6     <= scratch_nx[27:24];
            bcd7     <= scratch_nx[31:28];
            overflow <= ovf_pend;
            blank    <= blank_nx;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
